// File: rtl/lzc_norm_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : lzc_norm_pipe_if
// Description : Valid/ready bundle for the leading-zero normaliser. The input
//               beat (mantissa + exponent) and the result beat travel
//               together. The slave modport is the normaliser side, and the
//               master modport is the side that feeds and drains it.
// Revision    : 1.0 - initial release
// ============================================================================
interface lzc_norm_pipe_if #(
  parameter int WIDTH = 25,
  parameter int EXP_W = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mant;
  logic [EXP_W-1:0] in_exp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mant;
  logic [EXP_W-1:0] out_exp;
  logic [CW-1:0]    out_lz;
  logic             out_zero;
  logic             out_uflow;

  modport slave (
    input  in_valid, in_mant, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_lz, out_zero, out_uflow
  );

  modport master (
    output in_valid, in_mant, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_lz, out_zero, out_uflow
  );
endinterface
`default_nettype wire

// File: rtl/lzc_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module      : lzc_norm_pipe
// Description : Two-stage pipelined leading-zero counter and normaliser for
//               the FP adder. Stage 1 captures the mantissa, the exponent and
//               the leading-zero count. Stage 2 captures the left-shifted
//               mantissa, the adjusted exponent and the zero/underflow flags.
//               The shift is clamped so that the exponent never goes below
//               zero. Full valid/ready backpressure is supported.
// Revision    : 1.0 - initial release
// ============================================================================
module lzc_norm_pipe #(
  parameter  int WIDTH = 25,
  parameter  int EXP_W = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  lzc_norm_pipe_if.slave    bus
);

  // The lz-versus-exponent comparison is made wide enough that neither
  // operand wraps.
  localparam int MW = (CW > EXP_W) ? CW : EXP_W;

  // Stage 1 state
  logic             v1_q;
  logic [WIDTH-1:0] mant1_q;
  logic [EXP_W-1:0] exp1_q;
  logic [CW-1:0]    lz1_q;
  logic [CW-1:0]    lz1_d;

  // Stage 2 state
  logic             v2_q;
  logic [WIDTH-1:0] mant2_q, mant2_d;
  logic [EXP_W-1:0] exp2_q, exp2_d;
  logic [CW-1:0]    lz2_q;
  logic             zero2_q, zero2_d;
  logic             uflow2_q, uflow2_d;

  // Shared comparison operands
  logic [MW-1:0]    lz_ext;
  logic [MW-1:0]    exp_ext;

  // Pipeline advance enables
  logic             ld1;
  logic             ld2;

  // Stage 2 advances when it is empty or being drained. Stage 1 advances
  // when it is empty or stage 2 is taking its contents.
  assign ld2          = !v2_q || bus.out_ready;
  assign ld1          = !v1_q || ld2;
  assign bus.in_ready = ld1;

  // Priority encoder: the highest set bit wins, and all-zero gives WIDTH.
  always_comb begin
    lz1_d = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.in_mant[i]) begin
        lz1_d = CW'(WIDTH - 1 - i);
      end
    end
  end

  // Stage 1 register: capture the raw beat and its leading-zero count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      mant1_q <= '0;
      exp1_q  <= '0;
      lz1_q   <= '0;
    end else if (ld1) begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        mant1_q <= bus.in_mant;
        exp1_q  <= bus.in_exp;
        lz1_q   <= lz1_d;
      end
    end
  end

  // Normalise: shift by lz, or by the exponent when lz would take the
  // exponent below zero.
  always_comb begin
    lz_ext   = MW'(lz1_q);
    exp_ext  = MW'(exp1_q);
    zero2_d  = (mant1_q == '0);
    uflow2_d = 1'b0;
    mant2_d  = '0;
    exp2_d   = '0;
    if (!zero2_d) begin
      if (lz_ext > exp_ext) begin
        uflow2_d = 1'b1;
        mant2_d  = mant1_q << exp1_q;
      end else begin
        mant2_d  = mant1_q << lz1_q;
        exp2_d   = EXP_W'(exp_ext - lz_ext);
      end
    end
  end

  // Stage 2 register: hold the result until the downstream side takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q     <= 1'b0;
      mant2_q  <= '0;
      exp2_q   <= '0;
      lz2_q    <= '0;
      zero2_q  <= 1'b0;
      uflow2_q <= 1'b0;
    end else if (ld2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        mant2_q  <= mant2_d;
        exp2_q   <= exp2_d;
        lz2_q    <= lz1_q;
        zero2_q  <= zero2_d;
        uflow2_q <= uflow2_d;
      end
    end
  end

  assign bus.out_valid = v2_q;
  assign bus.out_mant  = mant2_q;
  assign bus.out_exp   = exp2_q;
  assign bus.out_lz    = lz2_q;
  assign bus.out_zero  = zero2_q;
  assign bus.out_uflow = uflow2_q;

endmodule
`default_nettype wire

// File: doc/lzc_norm_pipe.md
Name: lzc_norm_pipe

Overview:
- Parametrised, pipelined leading-zero counter and normaliser for the floating-point adder datapath.
- Takes an unnormalised mantissa and its exponent, and counts leading zeros from the MSB (MSB = carry position).
- Left-shifts the mantissa by that count and decrements the exponent by the same amount, clamping at exponent zero with an underflow flag.
- Two-stage valid/ready pipeline, so it can sit between the add stage and the rounding stage with full backpressure.

Parameters:
- WIDTH, 25, mantissa width in bits including the carry bit; must be >= 2.
- EXP_W, 8, exponent width in bits.
- CW, $clog2(WIDTH+1), width of the leading-zero count. Derived; do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_mant  input  WIDTH  unnormalised mantissa; bit WIDTH-1 is the carry bit.
- in_exp  input  EXP_W  unsigned biased exponent.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- out_mant  output  WIDTH  normalised mantissa.
- out_exp  output  EXP_W  adjusted exponent.
- out_lz  output  CW  raw leading-zero count of in_mant; equals WIDTH when in_mant is zero.
- out_zero  output  1  in_mant was all zeros.
- out_uflow  output  1  the shift was clamped by the exponent.

Behaviour:
- Reset:
  - clk and asynchronous active-low reset rst_n, fixed for this block.
  - While rst_n = 0, both stage-valid flags clear immediately.
  - out_valid = 0, and out_mant, out_exp, out_lz, out_zero, out_uflow = 0.
  - in_ready = 1 after reset.
  - Beats in flight at reset are discarded, with no partial output.
- Pipeline:
  - Stage 1 registers the inputs together with lz = the number of zeros above the highest set bit (priority from bit WIDTH-1 down).
  - Stage 2 registers the shifted mantissa, the exponent and the flags.
  - Latency: a beat accepted in cycle N is presented with out_valid = 1 in cycle N+2 if there are no stalls.
  - Throughput: 1 beat per cycle.
- Handshake:
  - A beat transfers on in_valid & in_ready, and on out_valid & out_ready.
  - Stage 2 loads when it is empty or out_ready = 1.
  - Stage 1 loads when it is empty or stage 2 loads.
  - in_ready = !v1 | !v2 | out_ready (combinational from out_ready; no combinational path from in_valid).
  - When out_valid = 1 and out_ready = 0, all out_* signals hold stable.
  - Order is preserved; no beat is dropped or duplicated.
  - Simultaneous accept and present in the same cycle is legal at full rate.
- Arithmetic:
  - Normal case (in_mant != 0 and lz <= in_exp):
    - out_mant = in_mant << lz
    - out_exp = in_exp - lz
    - out_uflow = 0
  - Underflow (in_mant != 0 and lz > in_exp):
    - out_mant = in_mant << in_exp
    - out_exp = 0
    - out_uflow = 1
  - Zero (in_mant == 0):
    - out_zero = 1, out_lz = WIDTH
    - out_mant = 0, out_exp = 0, out_uflow = 0
  - out_lz always reports the true lz, even when the shift was clamped.
  - Compare lz against in_exp at max(CW, EXP_W) bits; no wrap.
  - Bits shifted in from the right are 0.
  - With lz = 0 the mantissa passes through unchanged.

Test Plan:
(WIDTH=25, EXP_W=8, out_ready=1 unless stated; all hex values are 25-bit.)
- Carry set: in_mant=0x1000000, in_exp=10 -> two cycles later out_lz=0, out_mant=0x1000000, out_exp=10, out_zero=0, out_uflow=0.
- Deep normalise: in_mant=0x0000001, in_exp=100 -> out_lz=24, out_mant=0x1000000, out_exp=76.
- Zero input: in_mant=0, in_exp=50 -> out_zero=1, out_lz=25, out_mant=0, out_exp=0, out_uflow=0.
- Underflow clamp: in_mant=0x0000100 (lz=16), in_exp=5 -> out_uflow=1, out_lz=16, out_mant=0x0002000, out_exp=0.
- Backpressure: drive beats A, B, C back-to-back with out_ready=0.
  - A and B are accepted; in_ready drops to 0 with C pending.
  - out_* hold A stable for 5 cycles.
  - Raise out_ready: A, B, C emerge in order on consecutive cycles, with none lost or duplicated.
  - Sweep in_mant = 1<<k for k=0..24 at full rate -> out_lz=24-k on consecutive cycles.
- Reset mid-operation: with both stages valid, pulse rst_n low between clock edges.
  - out_valid falls without a clock edge.
  - All outputs read 0 and in_ready=1 after release.
  - The first new beat emerges 2 cycles after acceptance.
